// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a two-digit multiplexed 7-segment display.
// Synchronises COM/SEG, waits for a settled pattern and recovers the displayed hex digits.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] com_i,
  input  logic [6:0] seg_i,
  output logic [3:0] dig1_o,
  output logic [3:0] dig2_o,
  output logic       dig_valid_o,
  output logic       frame_stb_o,
  output logic [1:0] blank_o,
  output logic       seg_err_o,
  output logic       com_err_o
);

  localparam int unsigned CntW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic [1:0] com_s1_q, com_s2_q;
  logic [6:0] seg_s1_q, seg_s2_q;
  logic [8:0] s_prev_q;

  logic [3:0] dig1_q, dig2_q;
  logic       dig_valid_q;
  logic       frame_stb_q;
  logic [1:0] blank_q;
  logic [1:0] fresh_q;
  logic       seg_err_q;
  logic       com_err_q;

  logic [6:0] seg_fix;
  logic [8:0] s_cur;
  logic       com_onehot;
  logic       changed;
  logic       glyph_hit;
  logic [3:0] glyph_val;
  logic       is_blank;
  logic [1:0] fresh_upd;

  always_comb begin
    seg_fix    = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
    s_cur      = {com_s2_q, seg_fix};
    com_onehot = com_s2_q[0] ^ com_s2_q[1];
    changed    = (s_cur != s_prev_q);
    is_blank   = (seg_fix == 7'h00);
    // com_s2_q is one-hot whenever a capture happens, so it doubles as the digit mask.
    fresh_upd  = fresh_q | com_s2_q;
  end

  // Glyph table, active-high gfedcba.
  always_comb begin
    glyph_hit = 1'b1;
    glyph_val = 4'h0;
    case (seg_fix)
      7'h3F: glyph_val = 4'h0;
      7'h06: glyph_val = 4'h1;
      7'h5B: glyph_val = 4'h2;
      7'h4F: glyph_val = 4'h3;
      7'h66: glyph_val = 4'h4;
      7'h6D: glyph_val = 4'h5;
      7'h7D: glyph_val = 4'h6;
      7'h07: glyph_val = 4'h7;
      7'h7F: glyph_val = 4'h8;
      7'h6F: glyph_val = 4'h9;
      7'h77: glyph_val = 4'hA;
      7'h7C: glyph_val = 4'hB;
      7'h39: glyph_val = 4'hC;
      7'h5E: glyph_val = 4'hD;
      7'h79: glyph_val = 4'hE;
      7'h71: glyph_val = 4'hF;
      default: glyph_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      com_s1_q <= '0;
      com_s2_q <= '0;
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      s_prev_q <= '0;
    end else begin
      com_s1_q <= com_i;
      com_s2_q <= com_s1_q;
      seg_s1_q <= seg_i;
      seg_s2_q <= seg_s1_q;
      s_prev_q <= s_cur;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dig1_q      <= '0;
      dig2_q      <= '0;
      dig_valid_q <= 1'b0;
      frame_stb_q <= 1'b0;
      blank_q     <= '0;
      fresh_q     <= '0;
      seg_err_q   <= 1'b0;
      com_err_q   <= 1'b0;
    end else begin
      frame_stb_q <= 1'b0;
      seg_err_q   <= 1'b0;
      // Fires only on the cycle COMs first reads 11, not while it persists.
      com_err_q   <= (com_s2_q == 2'b11) && (s_prev_q[8:7] != 2'b11);
      unique case (state_q)
        StIdle: begin
          if (com_onehot) begin
            state_q <= StSettle;
            cnt_q   <= CntOne;
          end
        end
        StSettle: begin
          if (!com_onehot) begin
            state_q <= StIdle;
          end else if (changed) begin
            cnt_q <= CntOne;
          end else if (cnt_q == CntMax) begin
            state_q <= StHold;
            if (glyph_hit || is_blank) begin
              if (glyph_hit) begin
                if (com_s2_q[0]) dig1_q <= glyph_val;
                else             dig2_q <= glyph_val;
                blank_q <= blank_q & ~com_s2_q;
              end else begin
                blank_q <= blank_q | com_s2_q;
              end
              if (fresh_upd == 2'b11) begin
                frame_stb_q <= 1'b1;
                dig_valid_q <= 1'b1;
                fresh_q     <= 2'b00;
              end else begin
                fresh_q <= fresh_upd;
              end
            end else begin
              seg_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StHold: begin
          if (!com_onehot) begin
            state_q <= StIdle;
          end else if (changed) begin
            state_q <= StSettle;
            cnt_q   <= CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dig1_o      = dig1_q;
  assign dig2_o      = dig2_q;
  assign dig_valid_o = dig_valid_q;
  assign frame_stb_o = frame_stb_q;
  assign blank_o     = blank_q;
  assign seg_err_o   = seg_err_q;
  assign com_err_o   = com_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: an active-high and an active-low instance share one
// run-length based reference model; directed scenarios plus randomized scan phases.
module tb_seg_scan_decoder;

  localparam int Settle = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] com;
  logic [6:0] seg;
  logic [6:0] seg_n;

  logic [3:0] dig1_h, dig2_h, dig1_l, dig2_l;
  logic       valid_h, stb_h, serr_h, cerr_h;
  logic       valid_l, stb_l, serr_l, cerr_l;
  logic [1:0] blank_h, blank_l;

  assign seg_n = ~seg;

  seg_scan_decoder #(.SETTLE_CYCLES(Settle), .SEG_ACTIVE_LOW(1'b0)) u_dut_h (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .com_i      (com),
    .seg_i      (seg),
    .dig1_o     (dig1_h),
    .dig2_o     (dig2_h),
    .dig_valid_o(valid_h),
    .frame_stb_o(stb_h),
    .blank_o    (blank_h),
    .seg_err_o  (serr_h),
    .com_err_o  (cerr_h)
  );

  seg_scan_decoder #(.SETTLE_CYCLES(Settle), .SEG_ACTIVE_LOW(1'b1)) u_dut_l (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .com_i      (com),
    .seg_i      (seg_n),
    .dig1_o     (dig1_l),
    .dig2_o     (dig2_l),
    .dig_valid_o(valid_l),
    .frame_stb_o(stb_l),
    .blank_o    (blank_l),
    .seg_err_o  (serr_l),
    .com_err_o  (cerr_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int cnt_stb = 0;
  int cnt_serr = 0;
  int cnt_cerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [6:0] glyph_of(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Reference model: a pattern is captured once it has been seen unchanged for
  // Settle+1 consecutive cycles (after a 2-cycle sync delay) with one-hot COM.
  logic [1:0] m_p1c, m_p2c;
  logic [6:0] m_p1s, m_p2s;
  logic [8:0] m_prev, s;
  int         m_run;
  logic [3:0] m_dig1 = '0, m_dig2 = '0;
  logic [1:0] m_blank = '0, m_fresh = '0;
  logic       m_valid = 1'b0, m_stb = 1'b0, m_serr = 1'b0, m_cerr = 1'b0;

  always @(posedge clk) begin
    int hit;
    int d;
    if (!rst_n) begin
      m_p1c = '0; m_p2c = '0; m_p1s = '0; m_p2s = '0; m_prev = '0; m_run = 0;
      m_dig1 = '0; m_dig2 = '0; m_blank = '0; m_fresh = '0;
      m_valid = 1'b0; m_stb = 1'b0; m_serr = 1'b0; m_cerr = 1'b0;
    end else begin
      s = {m_p2c, m_p2s};
      m_cerr = (s[8:7] == 2'b11) && (m_prev[8:7] != 2'b11);
      m_stb = 1'b0;
      m_serr = 1'b0;
      if (s == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else m_run = 1;
      if ((s[8:7] == 2'b01 || s[8:7] == 2'b10) && m_run == Settle + 1) begin
        d = (s[8:7] == 2'b01) ? 0 : 1;
        hit = -1;
        for (int v = 0; v < 16; v++) if (glyph_of(v) == s[6:0]) hit = v;
        if (hit >= 0) begin
          if (d == 0) m_dig1 = 4'(hit);
          else m_dig2 = 4'(hit);
          m_blank[d] = 1'b0;
          m_fresh[d] = 1'b1;
        end else if (s[6:0] == 7'h00) begin
          m_blank[d] = 1'b1;
          m_fresh[d] = 1'b1;
        end else begin
          m_serr = 1'b1;
        end
        if (m_fresh == 2'b11) begin
          m_stb = 1'b1;
          m_valid = 1'b1;
          m_fresh = 2'b00;
        end
      end
      m_prev = s;
      m_p2c = m_p1c; m_p2s = m_p1s;
      m_p1c = com;   m_p1s = seg;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("dig1_h", 32'(dig1_h), 32'(m_dig1));
      chk("dig2_h", 32'(dig2_h), 32'(m_dig2));
      chk("valid_h", 32'(valid_h), 32'(m_valid));
      chk("stb_h", 32'(stb_h), 32'(m_stb));
      chk("blank_h", 32'(blank_h), 32'(m_blank));
      chk("serr_h", 32'(serr_h), 32'(m_serr));
      chk("cerr_h", 32'(cerr_h), 32'(m_cerr));
      chk("dig1_l", 32'(dig1_l), 32'(m_dig1));
      chk("dig2_l", 32'(dig2_l), 32'(m_dig2));
      chk("valid_l", 32'(valid_l), 32'(m_valid));
      chk("stb_l", 32'(stb_l), 32'(m_stb));
      chk("blank_l", 32'(blank_l), 32'(m_blank));
      chk("serr_l", 32'(serr_l), 32'(m_serr));
      chk("cerr_l", 32'(cerr_l), 32'(m_cerr));
      if (stb_h) cnt_stb++;
      if (serr_h) cnt_serr++;
      if (cerr_h) cnt_cerr++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int snap_stb, snap_serr, snap_cerr, r, len;
    rst_n = 1'b0;
    com = 2'b00;
    seg = 7'h00;

    // Reset with pins toggling, then quiet release.
    repeat (3) begin
      @(negedge clk);
      chk_en = 1'b1;
      com = 2'($urandom);
      seg = 7'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    com = 2'b00;
    seg = 7'h00;
    chk("rst_dig1", 32'(dig1_h), 0);
    chk("rst_outs", 32'({valid_h, stb_h, blank_h, serr_h, cerr_h, dig2_h}), 0);
    cycles(3);
    chk("post_rst_outs", 32'({dig1_l, dig2_l, valid_l, stb_l, blank_l, serr_l, cerr_l}), 0);

    // Digit 1 = 5, then digit 2 = 3; latency 2+4+1.
    com = 2'b01; seg = 7'h6D;
    cycles(6);
    chk("t2_dig1_early", 32'(dig1_h), 0);
    cycles(1);
    chk("t2_dig1_lat7", 32'(dig1_h), 5);
    cycles(3);
    snap_stb = cnt_stb;
    com = 2'b10; seg = 7'h4F;
    cycles(10);
    chk("t2_dig2", 32'(dig2_h), 3);
    chk("t2_one_stb", 32'(cnt_stb - snap_stb), 1);
    chk("t2_valid", 32'(valid_h), 1);

    // Short phase: no capture, no pulses.
    snap_stb = cnt_stb; snap_serr = cnt_serr; snap_cerr = cnt_cerr;
    com = 2'b01; seg = 7'h06;
    cycles(3);
    com = 2'b00;
    cycles(10);
    chk("t3_dig1_kept", 32'(dig1_h), 5);
    chk("t3_no_pulses", 32'((cnt_stb - snap_stb) + (cnt_serr - snap_serr) + (cnt_cerr - snap_cerr)), 0);

    // Non-glyph pattern.
    snap_serr = cnt_serr;
    com = 2'b10; seg = 7'h49;
    cycles(10);
    chk("t4_one_serr", 32'(cnt_serr - snap_serr), 1);
    chk("t4_dig2_kept", 32'(dig2_h), 3);

    // Both COM lines high, then a blank digit 1.
    snap_cerr = cnt_cerr;
    com = 2'b11;
    cycles(8);
    com = 2'b01; seg = 7'h00;
    cycles(10);
    chk("t5_one_cerr", 32'(cnt_cerr - snap_cerr), 1);
    chk("t5_blank1", 32'(blank_l), 32'h1);
    chk("t5_dig1_kept", 32'(dig1_l), 5);

    // Reset mid-settle, then a complete fresh settle.
    com = 2'b01; seg = 7'h5B;
    cycles(4);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(6);
    chk("t6_dig1_early", 32'(dig1_h), 0);
    cycles(1);
    chk("t6_dig1", 32'(dig1_h), 2);
    chk("t6_not_valid", 32'(valid_h), 0);
    com = 2'b10; seg = 7'h77;
    cycles(10);
    chk("t6_dig2", 32'(dig2_l), 32'hA);
    chk("t6_valid", 32'(valid_l), 1);

    // Randomized scan phases with glitches, gaps, overlaps and rare resets.
    repeat (450) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
      end
      r = int'($urandom_range(0, 99));
      if (r < 70) com = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      else if (r < 85) com = 2'b00;
      else com = 2'b11;
      r = int'($urandom_range(0, 99));
      if (r < 60) seg = glyph_of(int'($urandom_range(0, 15)));
      else if (r < 75) seg = 7'h00;
      else seg = 7'($urandom);
      len = int'($urandom_range(1, 12));
      cycles(len);
    end

    cycles(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
